spike_gen_scheduler: RTL and testbench

SPIKE_GEN_SCHEDULER -- requirements
Module: spike_gen_scheduler

---
 rtl/spike_gen_scheduler.sv | 177 +++++++++++++++++
 tb/tb_spike_gen_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_gen_scheduler.sv
// spike_gen_scheduler
//   Loads NUM_SPIKES rate words into a spike-generator memory, then runs a
//   number of two-cycle timesteps. Each step ORs the generator spike vector over
//   both phase cycles and reports it with a one-cycle strobe.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start, abort          run request (IDLE only) / cancel current LOAD or RUN
//   num_steps             timesteps per run, latched when start is accepted
//   rate_valid/rate_data  rate word stream; rate_ready is high throughout LOAD
//   gen_addr/gen_wen/gen_data  generator memory write port (combinational)
//   spikes                generator spike vector
//   step_valid/step_spikes  per-step strobe and captured spikes
//   busy, done            high in LOAD/RUN; one-cycle completion pulse
//   spike_total           (SPIKE_TOTAL_EN only) saturating count of reported spikes
//   dbg_state             current FSM state for observation
//
// Optional feature: define SPIKE_TOTAL_EN to add the spike_total counter.
//
// Handshake: a rate word transfers in any LOAD cycle where rate_valid and
// rate_ready are both high; rate_data must be stable in that cycle and the
// write to generator memory happens in the same cycle.
module spike_gen_scheduler #(
  parameter int NUM_SPIKES = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [STEP_WIDTH-1:0] num_steps,
  input  logic                  rate_valid,
  input  logic [DATA_WIDTH-1:0] rate_data,
  output logic                  rate_ready,
  output logic [ADDR_WIDTH-1:0] gen_addr,
  output logic                  gen_wen,
  output logic [DATA_WIDTH-1:0] gen_data,
  input  logic [NUM_SPIKES-1:0] spikes,
  output logic                  step_valid,
  output logic [NUM_SPIKES-1:0] step_spikes,
  output logic                  busy,
  output logic                  done,
`ifdef SPIKE_TOTAL_EN
  output logic [31:0]           spike_total,
`endif
  output logic [1:0]            dbg_state
);

  localparam int IDX_W = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPIKES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  phase_q, phase_d;
  logic [STEP_WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [STEP_WIDTH-1:0] num_steps_q, num_steps_d;
  logic [NUM_SPIKES-1:0] acc_q, acc_d;
  logic [NUM_SPIKES-1:0] step_spikes_q, step_spikes_d;
  logic                  step_valid_q, step_valid_d;
  logic [STEP_WIDTH:0]   step_next;
  logic                  start_acc;

  // One extra bit so num_steps = all-ones terminates instead of wrapping.
  assign step_next = {1'b0, step_cnt_q} + 1'b1;
  assign start_acc = (state_q == S_IDLE) && start && !abort;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    phase_d       = phase_q;
    step_cnt_d    = step_cnt_q;
    num_steps_d   = num_steps_q;
    acc_d         = acc_q;
    step_spikes_d = step_spikes_q;
    step_valid_d  = 1'b0;
    rate_ready    = 1'b0;
    gen_wen       = 1'b0;
    gen_addr      = '0;
    gen_data      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d     = S_LOAD;
          num_steps_d = num_steps;
          idx_d       = '0;
          step_cnt_d  = '0;
        end
      end
      S_LOAD: begin
        rate_ready = 1'b1;
        if (abort) begin
          state_d = S_IDLE;  // a coinciding handshake is dropped
        end else if (rate_valid) begin
          gen_wen  = 1'b1;
          gen_addr = ADDR_WIDTH'(idx_q);
          gen_data = rate_data;
          idx_d    = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = (num_steps_q == '0) ? S_DONE : S_RUN;
            phase_d = 1'b0;
            acc_d   = '0;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;  // also suppresses the strobe of a phase-1 abort
        end else if (!phase_q) begin
          acc_d   = spikes;
          phase_d = 1'b1;
        end else begin
          step_spikes_d = acc_q | spikes;
          step_valid_d  = 1'b1;
          phase_d       = 1'b0;
          step_cnt_d    = step_next[STEP_WIDTH-1:0];
          if (step_next == {1'b0, num_steps_q}) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      phase_q       <= 1'b0;
      step_cnt_q    <= '0;
      num_steps_q   <= '0;
      acc_q         <= '0;
      step_spikes_q <= '0;
      step_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      phase_q       <= phase_d;
      step_cnt_q    <= step_cnt_d;
      num_steps_q   <= num_steps_d;
      acc_q         <= acc_d;
      step_spikes_q <= step_spikes_d;
      step_valid_q  <= step_valid_d;
    end
  end

  assign step_valid  = step_valid_q;
  assign step_spikes = step_spikes_q;
  assign busy        = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign dbg_state   = state_q;

`ifdef SPIKE_TOTAL_EN
  logic [31:0] total_q, total_d, pop;
  logic [32:0] sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_SPIKES; i++) pop = pop + 32'(step_spikes_q[i]);
    sum     = {1'b0, total_q} + {1'b0, pop};
    total_d = total_q;
    if (start_acc) total_d = '0;
    else if (step_valid_q) total_d = sum[32] ? '1 : sum[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) total_q <= '0;
    else     total_q <= total_d;
  end

  assign spike_total = total_q;
`endif

endmodule

// File: tb/tb_spike_gen_scheduler.sv
// Bench for spike_gen_scheduler: directed scenarios with random rate words and
// random spike vectors; expectations are derived from the cycle-level timing
// rules (write cycle L, step k valid at L+3+2k built from spikes at L+1+2k and
// L+2+2k, done at L+2n+1) applied to logged stimulus.
module tb_spike_gen_scheduler;
  localparam int NS = 32;
  localparam int HIST = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_steps = '0;
  logic        rate_valid = 1'b0;
  logic [31:0] rate_data = '0;
  logic        rate_ready;
  logic [31:0] gen_addr;
  logic        gen_wen;
  logic [31:0] gen_data;
  logic [31:0] spikes = '0;
  logic        step_valid;
  logic [31:0] step_spikes;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;
`ifdef SPIKE_TOTAL_EN
  logic [31:0] spike_total;
`endif

  spike_gen_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_steps(num_steps),
    .rate_valid(rate_valid), .rate_data(rate_data), .rate_ready(rate_ready),
    .gen_addr(gen_addr), .gen_wen(gen_wen), .gen_data(gen_data),
    .spikes(spikes), .step_valid(step_valid), .step_spikes(step_spikes),
    .busy(busy), .done(done),
`ifdef SPIKE_TOTAL_EN
    .spike_total(spike_total),
`endif
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] spk_hist [0:HIST-1];
  int          wr_cyc_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          sv_cyc_q[$];
  logic [31:0] sv_val_q[$];
  int          done_cyc_q[$];
  bit last_busy, last_rdy, last_wen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    sv_cyc_q.delete(); sv_val_q.delete(); done_cyc_q.delete();
  endtask

  // Inputs are already driven; sample on the falling edge, advance one cycle.
  task automatic tick();
    if (cyc >= HIST - 1) begin
      $display("FAIL cycle_budget: observed %0d expected < %0d", cyc, HIST - 1);
      $fatal(1, "cycle budget");
    end
    spk_hist[cyc] = spikes;
    @(negedge clk);
    if (gen_wen) begin
      wr_cyc_q.push_back(cyc); wr_addr_q.push_back(gen_addr); wr_data_q.push_back(gen_data);
    end
    if (step_valid) begin sv_cyc_q.push_back(cyc); sv_val_q.push_back(step_spikes); end
    if (done) done_cyc_q.push_back(cyc);
    last_busy = busy; last_rdy = rate_ready; last_wen = gen_wen;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rate_ready"}, rate_ready, 0);
    check({tag, "_gen_wen"}, gen_wen, 0);
    check({tag, "_gen_addr"}, gen_addr, 0);
    check({tag, "_gen_data"}, gen_data, 0);
    check({tag, "_step_valid"}, step_valid, 0);
    check({tag, "_step_spikes"}, step_spikes, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
`ifdef SPIKE_TOTAL_EN
    check({tag, "_spike_total"}, spike_total, 0);
`endif
  endtask

  // Start plus 32 back-to-back words; leaves the DUT in its first RUN cycle.
  task automatic start_and_load(input int nsteps);
    clear_logs();
    start = 1'b1; num_steps = nsteps[15:0]; tick(); start = 1'b0;
    for (int i = 0; i < NS; i++) begin
      rate_valid = 1'b1; rate_data = $urandom; spikes = $urandom; tick();
    end
    rate_valid = 1'b0; rate_data = '0;
  endtask

  task automatic run_normal(input string tag, input int nsteps, input bit toggle,
                            input bit directed, input bit poke_start);
    logic [31:0] exp_q[$];
    logic [31:0] d;
    logic [31:0] exp_step;
    int sent, budget, lcyc;
    bit rdy_ok, busy_ok;
    longint tot;
    clear_logs();
    start = 1'b1; num_steps = nsteps[15:0]; spikes = '0; tick(); start = 1'b0;
    sent = 0; budget = 0; rdy_ok = 1; busy_ok = 1;
    while (sent < NS && budget < 200) begin
      if (poke_start) begin start = 1'($urandom_range(0, 1)); num_steps = 16'($urandom); end
      rate_valid = toggle ? ((budget % 2) == 0) : 1'b1;
      d = $urandom; rate_data = d;
      spikes = directed ? 32'h0 : $urandom;
      if (rate_valid) exp_q.push_back(d);
      tick();
      if (!last_rdy || !last_busy) rdy_ok = 0;
      if (rate_valid) sent++;
      budget++;
    end
    rate_valid = 1'b0; rate_data = '0;
    budget = 0;
    while (done_cyc_q.size() == 0 && budget < 2 * nsteps + 20) begin
      if (poke_start) start = 1'($urandom_range(0, 1));
      if (directed) spikes = (budget == 0) ? 32'h20 : 32'h0;
      else spikes = $urandom;
      tick();
      if (done_cyc_q.size() == 0 && !last_busy) busy_ok = 0;
      budget++;
    end
    start = 1'b0; spikes = '0;
    tick(); tick();
    check({tag, "_ready_busy_in_load"}, rdy_ok, 1);
    check({tag, "_busy_until_done"}, busy_ok, 1);
    check({tag, "_idle_after_done"}, last_busy, 0);
    check({tag, "_wr_count"}, wr_cyc_q.size(), NS);
    for (int i = 0; i < NS && i < wr_cyc_q.size(); i++) begin
      check({tag, "_wr_addr"}, wr_addr_q[i], i);
      check({tag, "_wr_data"}, wr_data_q[i], exp_q[i]);
    end
    lcyc = (wr_cyc_q.size() > 0) ? wr_cyc_q[wr_cyc_q.size() - 1] : -1;
    check({tag, "_step_count"}, sv_cyc_q.size(), nsteps);
    tot = 0;
    for (int k = 0; k < nsteps; k++) begin
      exp_step = (lcyc >= 0) ? (spk_hist[lcyc + 1 + 2 * k] | spk_hist[lcyc + 2 + 2 * k]) : 32'h0;
      tot += $countones(exp_step);
      if (k < sv_cyc_q.size() && lcyc >= 0) begin
        check({tag, "_step_cyc"}, sv_cyc_q[k], lcyc + 3 + 2 * k);
        check({tag, "_step_val"}, sv_val_q[k], exp_step);
      end
    end
    if (directed && sv_val_q.size() > 0) check({tag, "_step_bit5"}, sv_val_q[0], 32'h0000_0020);
    check({tag, "_done_count"}, done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0) check({tag, "_done_cyc"}, done_cyc_q[0], lcyc + 2 * nsteps + 1);
`ifdef SPIKE_TOTAL_EN
    check({tag, "_spike_total"}, spike_total, (tot > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : tot);
`endif
  endtask

  initial begin
    // reset block
    rst = 1'b1;
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_all_zero("post_reset");

    run_normal("basic3", 3, 0, 0, 0);
    run_normal("toggle", 4, 1, 0, 1);
    run_normal("zero_steps", 0, 0, 0, 0);
    run_normal("bit5", 1, 0, 1, 0);

    // abort on the 10th write, start while busy ignored
    clear_logs();
    start = 1'b1; num_steps = 16'd4; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rate_valid = 1'b1; rate_data = $urandom; abort = (i == 9); start = (i == 4);
      tick();
      if (i == 9) check("abort_load_wen", last_wen, 0);
    end
    abort = 1'b0; rate_valid = 1'b0; start = 1'b0;
    tick();
    check("abort_load_busy", last_busy, 0);
    check("abort_load_ready", last_rdy, 0);
    repeat (40) tick();
    check("abort_load_writes", wr_cyc_q.size(), 9);
    check("abort_load_done", done_cyc_q.size(), 0);
    check("abort_load_steps", sv_cyc_q.size(), 0);

    // abort and start together in IDLE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    tick();
    check("abort_start_idle", last_busy, 0);

    // abort during phase 1 of the second step
    start_and_load(5);
    for (int j = 0; j < 4; j++) begin
      spikes = $urandom; abort = (j == 3); tick();
    end
    abort = 1'b0; spikes = '0;
    repeat (10) tick();
    check("abort_run_steps", sv_cyc_q.size(), 1);
    check("abort_run_done", done_cyc_q.size(), 0);
    check("abort_run_busy", last_busy, 0);

    // asynchronous reset in the second step
    start_and_load(4);
    for (int j = 0; j < 3; j++) begin spikes = $urandom; tick(); end
    rst = 1'b1;
    #1;
    check_all_zero("rst_run");
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("rst_run_steps", sv_cyc_q.size(), 1);
    check("rst_run_done", done_cyc_q.size(), 0);
    check("rst_run_busy", last_busy, 0);
    run_normal("after_rst", 2, 0, 0, 0);

    for (int r = 0; r < 3; r++)
      run_normal("random", $urandom_range(1, 6), 1'($urandom_range(0, 1)), 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
